// File: rtl/wb_pkg.sv
// Shared encodings for the write-back stage: result sources, load funct3
// codes and the stall FSM state type.
package wb_pkg;

   // Result source select
   localparam logic [1:0] WB_SEL_ALU = 2'd0;
   localparam logic [1:0] WB_SEL_MEM = 2'd1;
   localparam logic [1:0] WB_SEL_PC4 = 2'd2;
   localparam logic [1:0] WB_SEL_IMM = 2'd3;

   // Load funct3 encodings
   localparam logic [2:0] F3_LB  = 3'b000;
   localparam logic [2:0] F3_LH  = 3'b001;
   localparam logic [2:0] F3_LW  = 3'b010;
   localparam logic [2:0] F3_LD  = 3'b011;
   localparam logic [2:0] F3_LBU = 3'b100;
   localparam logic [2:0] F3_LHU = 3'b101;
   localparam logic [2:0] F3_LWU = 3'b110;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_WAIT = 1'b1
   } wb_state_e;

   // Width of the byte offset within one XLEN word
   function automatic int off_width(input int xlen);
      return $clog2(xlen / 8);
   endfunction

endpackage

// File: rtl/wb_stage_load_extend.sv
// Load alignment and sign/zero extension. Purely combinational; selects the
// addressed byte/half/word little-endian from the aligned memory word and
// flags illegal funct3 codes and misaligned offsets.
module load_extend
   import wb_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic [2:0]                  i_funct3,
   input  logic [off_width(XLEN)-1:0]  i_off,
   input  logic [XLEN-1:0]             i_rdata,
   output logic [XLEN-1:0]             o_data,
   output logic                        o_err
);

   logic [XLEN-1:0] w_sh;

   // Bring the addressed lane down to bit 0
   assign w_sh = i_rdata >> {i_off, 3'b000};

   // Extension and legality per load type
   always_comb begin
      o_data = '0;
      o_err  = 1'b0;
      case (i_funct3)
         F3_LB:  o_data = {{(XLEN-8){w_sh[7]}}, w_sh[7:0]};
         F3_LBU: o_data = {{(XLEN-8){1'b0}}, w_sh[7:0]};
         F3_LH: begin
            o_err  = i_off[0];
            o_data = {{(XLEN-16){w_sh[15]}}, w_sh[15:0]};
         end
         F3_LHU: begin
            o_err  = i_off[0];
            o_data = {{(XLEN-16){1'b0}}, w_sh[15:0]};
         end
         F3_LW: begin
            o_err  = |i_off[1:0];
            o_data = w_sh;
            // Upper half only exists on RV64; loop is empty for XLEN=32
            for (int i = 32; i < XLEN; i++) o_data[i] = w_sh[31];
         end
         F3_LWU: begin
            o_err  = (XLEN != 64) || (|i_off[1:0]);
            o_data = w_sh;
            for (int i = 32; i < XLEN; i++) o_data[i] = 1'b0;
         end
         F3_LD: begin
            o_err  = (XLEN != 64) || (|i_off);
            o_data = w_sh;
         end
         default: o_err = 1'b1;
      endcase
   end

endmodule

// File: rtl/wb_stage.sv
// Registered write-back stage: four-way result mux, load extension, a
// two-state stall FSM for slow data-memory reads, and a 64-bit retired
// instruction counter. rf_wdata doubles as the next-cycle forwarding value.
module wb_stage
   import wb_pkg::*;
#(
   parameter int XLEN   = 32,
   parameter int REG_AW = 5
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_valid,
   input  logic [REG_AW-1:0] i_rd,
   input  logic              i_reg_write,
   input  logic [1:0]        i_wb_sel,
   input  logic [2:0]        i_funct3,
   input  logic [XLEN-1:0]   i_alu_result,
   input  logic [XLEN-1:0]   i_pc_plus4,
   input  logic [XLEN-1:0]   i_imm,
   input  logic [XLEN-1:0]   i_mem_rdata,
   input  logic              i_mem_rvalid,
   output logic              o_stall,
   output logic              o_rf_we,
   output logic [REG_AW-1:0] o_rf_waddr,
   output logic [XLEN-1:0]   o_rf_wdata,
   output logic              o_load_err,
   output logic [63:0]       o_instret
);

   localparam int OFFW = off_width(XLEN);

   wb_state_e         r_state, w_state_nxt;
   logic [REG_AW-1:0] r_hold_rd;
   logic              r_hold_we;
   logic [2:0]        r_hold_f3;
   logic [OFFW-1:0]   r_hold_off;

   logic              r_rf_we;
   logic [REG_AW-1:0] r_rf_waddr;
   logic [XLEN-1:0]   r_rf_wdata;
   logic              r_load_err;
   logic [63:0]       r_instret;

   logic              w_is_load;
   logic [2:0]        w_ext_f3;
   logic [OFFW-1:0]   w_ext_off;
   logic [XLEN-1:0]   w_ld_data;
   logic              w_ld_err;

   logic              w_stall;
   logic              w_retire;
   logic              w_wr;
   logic              w_err;
   logic              w_capture;
   logic [REG_AW-1:0] w_waddr;
   logic [XLEN-1:0]   w_wdata;
   logic [63:0]       w_instret_nxt;

   assign w_is_load = (i_wb_sel == WB_SEL_MEM);

   // One extender serves both paths: held control while waiting, live otherwise
   assign w_ext_f3  = (r_state == ST_WAIT) ? r_hold_f3  : i_funct3;
   assign w_ext_off = (r_state == ST_WAIT) ? r_hold_off : i_alu_result[OFFW-1:0];

   load_extend #(.XLEN(XLEN)) u_ext (
      .i_funct3 (w_ext_f3),
      .i_off    (w_ext_off),
      .i_rdata  (i_mem_rdata),
      .o_data   (w_ld_data),
      .o_err    (w_ld_err)
   );

   assign w_instret_nxt = r_instret + 64'd1;

   // Next state, stall and the result to be registered this edge
   always_comb begin
      w_state_nxt = r_state;
      w_stall     = 1'b0;
      w_retire    = 1'b0;
      w_wr        = 1'b0;
      w_err       = 1'b0;
      w_capture   = 1'b0;
      w_waddr     = i_rd;
      w_wdata     = i_alu_result;
      case (r_state)
         ST_IDLE: begin
            case (i_wb_sel)
               WB_SEL_MEM: w_wdata = w_ld_data;
               WB_SEL_PC4: w_wdata = i_pc_plus4;
               WB_SEL_IMM: w_wdata = i_imm;
               default:    w_wdata = i_alu_result;
            endcase
            if (i_valid) begin
               if (w_is_load && w_ld_err) begin
                  // Bad loads retire immediately and never wait on memory
                  w_retire = 1'b1;
                  w_err    = 1'b1;
               end else if (w_is_load && !i_mem_rvalid) begin
                  w_stall     = 1'b1;
                  w_capture   = 1'b1;
                  w_state_nxt = ST_WAIT;
               end else begin
                  w_retire = 1'b1;
                  w_wr     = i_reg_write && (i_rd != '0);
               end
            end
         end
         ST_WAIT: begin
            w_waddr = r_hold_rd;
            w_wdata = w_ld_data;
            if (i_mem_rvalid) begin
               w_retire    = 1'b1;
               w_wr        = r_hold_we && (r_hold_rd != '0);
               w_state_nxt = ST_IDLE;
            end else begin
               w_stall = 1'b1;
            end
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   // FSM state and pending-load hold registers
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state    <= ST_IDLE;
         r_hold_rd  <= '0;
         r_hold_we  <= 1'b0;
         r_hold_f3  <= '0;
         r_hold_off <= '0;
      end else begin
         r_state <= w_state_nxt;
         if (w_capture) begin
            r_hold_rd  <= i_rd;
            r_hold_we  <= i_reg_write;
            r_hold_f3  <= i_funct3;
            r_hold_off <= i_alu_result[OFFW-1:0];
         end
      end
   end

   // Register-file write port and error pulse
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_rf_we    <= 1'b0;
         r_rf_waddr <= '0;
         r_rf_wdata <= '0;
         r_load_err <= 1'b0;
      end else begin
         r_rf_we    <= w_wr;
         r_load_err <= w_err;
         if (w_wr) begin
            r_rf_waddr <= w_waddr;
            r_rf_wdata <= w_wdata;
         end
      end
   end

   // Retired-instruction counter, wraps naturally at 2^64
   always_ff @(posedge i_clk) begin
      if (i_rst)         r_instret <= '0;
      else if (w_retire) r_instret <= w_instret_nxt;
   end

   assign o_stall    = w_stall;
   assign o_rf_we    = r_rf_we;
   assign o_rf_waddr = r_rf_waddr;
   assign o_rf_wdata = r_rf_wdata;
   assign o_load_err = r_load_err;
   assign o_instret  = r_instret;

endmodule

// File: tb/tb_wb_stage.sv
// Directed bench for wb_stage: one XLEN=32 and one XLEN=64 instance, a
// vector table for single-cycle instructions, and hand sequences for the
// multi-cycle load, reset-in-WAIT and counter wrap.
module tb_wb_stage;
   import wb_pkg::*;

   typedef struct {
      logic        is64;
      logic [4:0]  rd;
      logic        rw;
      logic [1:0]  sel;
      logic [2:0]  f3;
      logic [63:0] alu;
      logic [63:0] pc4;
      logic [63:0] imm;
      logic [63:0] rdata;
      logic        exp_we;
      logic [63:0] exp_wdata;
      logic        exp_err;
   } vec_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   // XLEN=32 instance signals
   logic        a_valid = 0, a_rw = 0, a_rvalid = 0;
   logic [4:0]  a_rd = 0;
   logic [1:0]  a_sel = 0;
   logic [2:0]  a_f3 = 0;
   logic [31:0] a_alu = 0, a_pc4 = 0, a_imm = 0, a_rdata = 0;
   logic        a_stall, a_we, a_err;
   logic [4:0]  a_waddr;
   logic [31:0] a_wdata;
   logic [63:0] a_instret;

   // XLEN=64 instance signals
   logic        b_valid = 0, b_rw = 0, b_rvalid = 0;
   logic [4:0]  b_rd = 0;
   logic [1:0]  b_sel = 0;
   logic [2:0]  b_f3 = 0;
   logic [63:0] b_alu = 0, b_pc4 = 0, b_imm = 0, b_rdata = 0;
   logic        b_stall, b_we, b_err;
   logic [4:0]  b_waddr;
   logic [63:0] b_wdata;
   logic [63:0] b_instret;

   wb_stage #(.XLEN(32), .REG_AW(5)) dut32 (
      .i_clk(clk), .i_rst(rst), .i_valid(a_valid), .i_rd(a_rd),
      .i_reg_write(a_rw), .i_wb_sel(a_sel), .i_funct3(a_f3),
      .i_alu_result(a_alu), .i_pc_plus4(a_pc4), .i_imm(a_imm),
      .i_mem_rdata(a_rdata), .i_mem_rvalid(a_rvalid), .o_stall(a_stall),
      .o_rf_we(a_we), .o_rf_waddr(a_waddr), .o_rf_wdata(a_wdata),
      .o_load_err(a_err), .o_instret(a_instret)
   );

   wb_stage #(.XLEN(64), .REG_AW(5)) dut64 (
      .i_clk(clk), .i_rst(rst), .i_valid(b_valid), .i_rd(b_rd),
      .i_reg_write(b_rw), .i_wb_sel(b_sel), .i_funct3(b_f3),
      .i_alu_result(b_alu), .i_pc_plus4(b_pc4), .i_imm(b_imm),
      .i_mem_rdata(b_rdata), .i_mem_rvalid(b_rvalid), .o_stall(b_stall),
      .o_rf_we(b_we), .o_rf_waddr(b_waddr), .o_rf_wdata(b_wdata),
      .o_load_err(b_err), .o_instret(b_instret)
   );

   int n_tot = 0;
   int n_pass = 0;
   logic [63:0] exp_ir32 = 0, exp_ir64 = 0;
   vec_t tv[$];

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_tot++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
   endtask

   function automatic vec_t mk(input logic is64, input logic [4:0] rd, input logic rw,
                               input logic [1:0] sel, input logic [2:0] f3,
                               input logic [63:0] alu, input logic [63:0] pc4,
                               input logic [63:0] imm, input logic [63:0] rdata,
                               input logic we, input logic [63:0] wd, input logic err);
      vec_t v;
      v.is64 = is64; v.rd = rd; v.rw = rw; v.sel = sel; v.f3 = f3;
      v.alu = alu; v.pc4 = pc4; v.imm = imm; v.rdata = rdata;
      v.exp_we = we; v.exp_wdata = wd; v.exp_err = err;
      return v;
   endfunction

   task automatic drive(input vec_t v);
      a_valid = !v.is64; b_valid = v.is64;
      a_rd = v.rd; a_rw = v.rw; a_sel = v.sel; a_f3 = v.f3;
      a_alu = v.alu[31:0]; a_pc4 = v.pc4[31:0]; a_imm = v.imm[31:0];
      a_rdata = v.rdata[31:0]; a_rvalid = 1'b1;
      b_rd = v.rd; b_rw = v.rw; b_sel = v.sel; b_f3 = v.f3;
      b_alu = v.alu; b_pc4 = v.pc4; b_imm = v.imm;
      b_rdata = v.rdata; b_rvalid = 1'b1;
   endtask

   task automatic idle();
      a_valid = 0; b_valid = 0; a_rvalid = 0; b_rvalid = 0;
   endtask

   initial begin
      // Single-cycle instructions: {is64, rd, rw, sel, f3, alu, pc4, imm, rdata, we, wdata, err}
      tv.push_back(mk(0,  5, 1, WB_SEL_ALU, 3'd0,   64'h1234, 0, 0, 0,               1, 64'h1234, 0));
      tv.push_back(mk(0,  6, 1, WB_SEL_MEM, F3_LB,  64'h1003, 0, 0, 64'h80FFFFFF,    1, 64'hFFFFFF80, 0));
      tv.push_back(mk(0,  6, 1, WB_SEL_MEM, F3_LBU, 64'h1003, 0, 0, 64'h80FFFFFF,    1, 64'h00000080, 0));
      tv.push_back(mk(0,  7, 1, WB_SEL_PC4, 3'd0,   64'h55, 64'h104, 0, 0,           1, 64'h104, 0));
      tv.push_back(mk(0,  8, 1, WB_SEL_IMM, 3'd0,   64'h55, 0, 64'hABCD0000, 0,      1, 64'hABCD0000, 0));
      tv.push_back(mk(0,  9, 1, WB_SEL_MEM, F3_LW,  64'h1001, 0, 0, 64'h11223344,    0, 0, 1));
      tv.push_back(mk(0,  0, 1, WB_SEL_ALU, 3'd0,   64'h77, 0, 0, 0,                 0, 0, 0));
      tv.push_back(mk(0, 11, 1, WB_SEL_MEM, F3_LHU, 64'h1002, 0, 0, 64'h80010000,    1, 64'h00008001, 0));
      tv.push_back(mk(0, 11, 1, WB_SEL_MEM, F3_LH,  64'h1002, 0, 0, 64'h80010000,    1, 64'hFFFF8001, 0));
      tv.push_back(mk(0, 12, 1, WB_SEL_MEM, F3_LH,  64'h1000, 0, 0, 64'h00007FFF,    1, 64'h00007FFF, 0));
      tv.push_back(mk(0, 13, 1, WB_SEL_MEM, F3_LW,  64'h2000, 0, 0, 64'hDEADBEEF,    1, 64'hDEADBEEF, 0));
      tv.push_back(mk(0, 14, 1, WB_SEL_MEM, F3_LD,  64'h2000, 0, 0, 64'hDEADBEEF,    0, 0, 1));
      tv.push_back(mk(0, 14, 1, WB_SEL_MEM, F3_LWU, 64'h2000, 0, 0, 64'hDEADBEEF,    0, 0, 1));
      tv.push_back(mk(0, 15, 1, WB_SEL_MEM, 3'b111, 64'h2000, 0, 0, 64'hDEADBEEF,    0, 0, 1));
      tv.push_back(mk(0, 16, 0, WB_SEL_ALU, 3'd0,   64'h99, 0, 0, 0,                 0, 0, 0));
      tv.push_back(mk(0, 17, 1, WB_SEL_MEM, F3_LB,  64'h2001, 0, 0, 64'h00007F00,    1, 64'h7F, 0));
      tv.push_back(mk(0, 18, 1, WB_SEL_MEM, F3_LH,  64'h1001, 0, 0, 64'h12345678,    0, 0, 1));
      tv.push_back(mk(1,  3, 1, WB_SEL_MEM, F3_LWU, 64'h4, 0, 0, 64'hF0000000_00000000, 1, 64'h00000000_F0000000, 0));
      tv.push_back(mk(1,  3, 1, WB_SEL_MEM, F3_LW,  64'h4, 0, 0, 64'hF0000000_00000000, 1, 64'hFFFFFFFF_F0000000, 0));
      tv.push_back(mk(1,  4, 1, WB_SEL_MEM, F3_LD,  64'h4, 0, 0, 64'hF0000000_00000000, 0, 0, 1));
      tv.push_back(mk(1,  4, 1, WB_SEL_MEM, F3_LD,  64'h8, 0, 0, 64'h01234567_89ABCDEF, 1, 64'h01234567_89ABCDEF, 0));
      tv.push_back(mk(1,  5, 1, WB_SEL_MEM, F3_LB,  64'h7, 0, 0, 64'h80000000_00000000, 1, 64'hFFFFFFFF_FFFFFF80, 0));
      tv.push_back(mk(1,  6, 1, WB_SEL_ALU, 3'd0,   64'hFEDCBA98_76543210, 0, 0, 0,   1, 64'hFEDCBA98_76543210, 0));
      tv.push_back(mk(1,  6, 1, WB_SEL_MEM, F3_LH,  64'h6, 0, 0, 64'h12340000_00000000, 1, 64'h1234, 0));

      // Reset and reset state
      repeat (2) @(posedge clk);
      @(negedge clk); rst = 0;
      #1;
      chk("rst_we",      {63'd0, a_we},  0);
      chk("rst_waddr",   {59'd0, a_waddr}, 0);
      chk("rst_wdata",   {32'd0, a_wdata}, 0);
      chk("rst_err",     {63'd0, a_err}, 0);
      chk("rst_instret", a_instret, 0);
      chk("rst_stall",   {63'd0, a_stall}, 0);
      chk("rst64_instret", b_instret, 0);

      // Table: back-to-back single-cycle instructions
      foreach (tv[i]) begin
         @(negedge clk);
         drive(tv[i]);
         #1;
         chk($sformatf("v%0d_stall", i), {63'd0, tv[i].is64 ? b_stall : a_stall}, 0);
         @(posedge clk); #1;
         if (tv[i].is64) begin
            exp_ir64++;
            chk($sformatf("v%0d_we", i),  {63'd0, b_we},  {63'd0, tv[i].exp_we});
            chk($sformatf("v%0d_err", i), {63'd0, b_err}, {63'd0, tv[i].exp_err});
            chk($sformatf("v%0d_instret", i), b_instret, exp_ir64);
            if (tv[i].exp_we) begin
               chk($sformatf("v%0d_waddr", i), {59'd0, b_waddr}, {59'd0, tv[i].rd});
               chk($sformatf("v%0d_wdata", i), b_wdata, tv[i].exp_wdata);
            end
         end else begin
            exp_ir32++;
            chk($sformatf("v%0d_we", i),  {63'd0, a_we},  {63'd0, tv[i].exp_we});
            chk($sformatf("v%0d_err", i), {63'd0, a_err}, {63'd0, tv[i].exp_err});
            chk($sformatf("v%0d_instret", i), a_instret, exp_ir32);
            if (tv[i].exp_we) begin
               chk($sformatf("v%0d_waddr", i), {59'd0, a_waddr}, {59'd0, tv[i].rd});
               chk($sformatf("v%0d_wdata", i), {32'd0, a_wdata}, tv[i].exp_wdata);
            end
         end
      end
      @(negedge clk); idle();
      @(posedge clk); #1;
      chk("idle_we32", {63'd0, a_we}, 0);
      chk("idle_we64", {63'd0, b_we}, 0);
      chk("idle_err32", {63'd0, a_err}, 0);

      // Multi-cycle LH: three wait cycles then data
      @(negedge clk);
      a_valid = 1; a_rd = 10; a_rw = 1; a_sel = WB_SEL_MEM; a_f3 = F3_LH;
      a_alu = 32'h2002; a_rvalid = 0; a_rdata = 32'h0;
      for (int k = 0; k < 3; k++) begin
         #1;
         chk($sformatf("mc_stall%0d", k), {63'd0, a_stall}, 1);
         @(posedge clk); #1;
         chk($sformatf("mc_nowe%0d", k), {63'd0, a_we}, 0);
         @(negedge clk);
      end
      a_rvalid = 1; a_rdata = 32'hBEEF0000;
      #1;
      chk("mc_stall_rel", {63'd0, a_stall}, 0);
      @(posedge clk); #1;
      exp_ir32++;
      chk("mc_we", {63'd0, a_we}, 1);
      chk("mc_waddr", {59'd0, a_waddr}, 10);
      chk("mc_wdata", {32'd0, a_wdata}, 64'hFFFFBEEF);
      chk("mc_instret", a_instret, exp_ir32);
      @(negedge clk); idle();
      #1;
      chk("mc_stall_after", {63'd0, a_stall}, 0);
      @(posedge clk); #1;
      chk("mc_we_pulse", {63'd0, a_we}, 0);

      // Reset while a load is pending
      @(negedge clk);
      a_valid = 1; a_rd = 12; a_rw = 1; a_sel = WB_SEL_MEM; a_f3 = F3_LW;
      a_alu = 32'h3000; a_rvalid = 0;
      #1;
      chk("rw_stall", {63'd0, a_stall}, 1);
      @(posedge clk);
      @(negedge clk);
      rst = 1; a_valid = 0; a_rvalid = 1; a_rdata = 32'hCAFEF00D;
      @(posedge clk);
      @(negedge clk);
      rst = 0;
      exp_ir32 = 0; exp_ir64 = 0;
      #1;
      chk("rw_stall_post", {63'd0, a_stall}, 0);
      @(posedge clk); #1;
      chk("rw_we", {63'd0, a_we}, 0);
      chk("rw_instret", a_instret, 0);
      @(negedge clk); idle();

      // 64-bit counter wrap
      @(negedge clk);
      force dut64.r_instret = 64'hFFFF_FFFF_FFFF_FFFF;
      b_valid = 1; b_rd = 1; b_rw = 1; b_sel = WB_SEL_ALU; b_alu = 64'h42;
      #1;
      release dut64.r_instret;
      #1;
      chk("wrap_pre", b_instret, 64'hFFFF_FFFF_FFFF_FFFF);
      @(posedge clk); #1;
      chk("wrap_post", b_instret, 0);
      chk("wrap_we", {63'd0, b_we}, 1);
      @(negedge clk); idle();
      @(posedge clk); #1;

      $display("%0d/%0d checks passed", n_pass, n_tot);
      $finish;
   end

endmodule
